posicion_mano_rx: RTL and testbench
===================================

Name: posicion_mano_rx

Overview:
- Framing/filtering stage between the UART receiver and the basket (Canasta) logic.
- Parses a 3-byte serial frame (header, high, low) into a 10-bit hand X position.
- Clamps the position to the playable range, smooths it with a moving average, and presents it as pos_x_mano.
- Updates its output only on a frame-start tick, so the basket never moves mid-scan.

Parameters:
- HEADER, 8'hA5, frame start byte.
- X_MAX, 576, largest legal position (640 minus basket width 64).
- X_RESET, 288, position after reset.
- AVG_LOG2, 2, log2 of averaging depth (depth 4).
- TIMEOUT_CYC, 500000, idle cycles allowed between bytes of one frame (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_byte  in  8  byte from UART, valid when received=1
- received  in  1  one-cycle strobe, new byte available
- recv_error  in  1  one-cycle strobe, UART framing error
- frame_tick  in  1  one-cycle strobe at start of vertical blank
- pos_x_mano  out  10  filtered position to basket logic
- frame_ok  out  1  one-cycle pulse per accepted frame
- err_count  out  8  saturating count of dropped frames

Behaviour:
- Reset (asynchronous, active-high) sets:
  - pos_x_mano=X_RESET, frame_ok=0, err_count=0.
  - FSM=IDLE; all AVG depth buffer entries=X_RESET; pending=X_RESET; timeout counter=0.
- FSM states: IDLE, WAIT_HI, WAIT_LO, COMMIT.
- IDLE:
  - received with rx_byte==HEADER -> WAIT_HI.
  - Any other byte is ignored, with no error.
- WAIT_HI, on received:
  - rx_byte[7:2]==0 -> hi<=rx_byte[1:0], go WAIT_LO.
  - rx_byte==HEADER -> stay WAIT_HI (resync), no error.
  - Any other value -> IDLE, err_count++.
- WAIT_LO, on received:
  - Any value is accepted, including HEADER.
  - raw<={hi,rx_byte}, go COMMIT.
- COMMIT (one cycle):
  - clamped = (raw>X_MAX) ? X_MAX : raw.
  - Shift clamped into the average buffer, oldest entry out.
  - frame_ok=1 for this cycle; return to IDLE.
- Average: sum held in a 12-bit register (10+AVG_LOG2 bits), updated one cycle after COMMIT; pending<=sum>>AVG_LOG2 (truncating).
- Latency:
  - Low-byte strobe at cycle t -> COMMIT at t+1 -> pending valid at t+3.
  - pos_x_mano<=pending on the first frame_tick after t+3.
- frame_tick in the same cycle as a pending update: the old pending is output; the new value goes out at the next tick.
- Timeout:
  - Counter runs in WAIT_HI and WAIT_LO and clears on every received.
  - Reaching TIMEOUT_CYC -> IDLE, err_count++.
- recv_error:
  - In WAIT_HI or WAIT_LO -> IDLE, err_count++.
  - In IDLE: ignored.
  - If recv_error and received arrive in the same cycle, recv_error wins and the byte is discarded.
- err_count saturates at 255 (no wrap).
- Reset mid-frame: partial frame discarded; buffer and outputs return to reset values immediately.

Decomposition:
- Shared package holds:
  - HEADER, X_MAX, X_RESET.
  - Screen width 640.
  - FSM state encoding (2 bits).
- Natural sub-module: prom_movil. It takes the sample-in strobe and 10-bit sample, keeps the shift buffer and running sum (add new, subtract oldest), and outputs the 10-bit average plus a valid strobe.
- The FSM, timeout counter, error counter, and frame_tick output register stay in posicion_mano_rx.

Test Plan:
- Reset, then frames A5,01,90 (raw 400):
  - First average = (288*3+400)/4 = 316.
  - pos_x_mano=316 at the next frame_tick; frame_ok pulses once.
- Four frames A5,03,FF (raw 1023): clamped to 576 each time; after the 4th frame plus a tick, pos_x_mano=576.
- Bytes 00,A5,A5,00,64:
  - Leading 00 ignored; second A5 resyncs.
  - raw=100 is accepted; err_count stays 0.
- A5,07 (bad high byte) -> err_count=1, no frame_ok. Then A5,00,C8 is accepted; average moves toward 200.
- A5,00, then no byte for TIMEOUT_CYC cycles -> err_count++ and FSM back to IDLE. A later low byte alone produces no frame_ok.
- Low-byte strobe placed so that frame_tick coincides with the pending update: pos_x_mano keeps the old value and updates on the following tick. Then assert reset mid-frame: pos_x_mano=288 immediately, err_count=0.

Source files
------------

// File: rtl/posicion_mano_rx_pkg.sv
// Shared constants and FSM encoding for the hand-position frame receiver.
package posicion_mano_rx_pkg;

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam int         SCREEN_W = 640;
  localparam int         BASKET_W = 64;
  localparam logic [9:0] X_MAX    = 10'(SCREEN_W - BASKET_W);
  localparam logic [9:0] X_RESET  = 10'd288;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    COMMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/posicion_mano_rx_prom_movil.sv
// Moving average over 2**AVG_LOG2 samples using a shift history and running sum.
module prom_movil #(
  parameter int                 DATA_W    = 10,
  parameter int                 AVG_LOG2  = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg,
  output logic              avg_vld
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam logic [SUM_W-1:0] SUM_RESET = SUM_W'(RESET_VAL) << AVG_LOG2;

  logic [DATA_W-1:0] hist_p1 [DEPTH];
  logic [SUM_W-1:0]  sum_p1;
  logic              vld_p1;

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:AVG_LOG2];
  endfunction

  // Stage p1: history shift and running sum (add newest, drop oldest)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) hist_p1[i] <= RESET_VAL;
      sum_p1 <= SUM_RESET;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= sample_vld;
      if (sample_vld) begin
        hist_p1[0] <= sample;
        for (int i = 1; i < DEPTH; i++) hist_p1[i] <= hist_p1[i-1];
        sum_p1 <= sum_p1 + SUM_W'(sample) - SUM_W'(hist_p1[DEPTH-1]);
      end
    end
  end

  assign avg     = avg_trunc(sum_p1);
  assign avg_vld = vld_p1;

endmodule

// File: rtl/posicion_mano_rx.sv
// Parses A5/hi/lo frames into a clamped, averaged hand X position, released on frame_tick.
module posicion_mano_rx #(
  parameter logic [7:0] HEADER      = posicion_mano_rx_pkg::HEADER,
  parameter logic [9:0] X_MAX       = posicion_mano_rx_pkg::X_MAX,
  parameter logic [9:0] X_RESET     = posicion_mano_rx_pkg::X_RESET,
  parameter int         AVG_LOG2    = 2,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       received,
  input  logic       recv_error,
  input  logic       frame_tick,
  output logic [9:0] pos_x_mano,
  output logic       frame_ok,
  output logic [7:0] err_count
);

  import posicion_mano_rx_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state, next;
  logic [1:0]       hi;
  logic [9:0]       raw;
  logic [CNT_W-1:0] tmo_cnt;
  logic [9:0]       pending, avg;
  logic             avg_vld, err_inc, hi_load, lo_load, timeout, in_wait;

  function automatic logic [9:0] clamp_x(input logic [9:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  assign timeout = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign in_wait = (state == WAIT_HI) || (state == WAIT_LO);

  always_comb begin
    next     = state;
    err_inc  = 1'b0;
    hi_load  = 1'b0;
    lo_load  = 1'b0;
    frame_ok = 1'b0;
    case (state)
      IDLE: begin
        if (received && !recv_error && rx_byte == HEADER) next = WAIT_HI;
      end
      WAIT_HI: begin
        if (recv_error) begin
          next = IDLE; err_inc = 1'b1;
        end else if (received) begin
          if (rx_byte[7:2] == 6'd0) begin
            hi_load = 1'b1; next = WAIT_LO;
          end else if (rx_byte != HEADER) begin
            next = IDLE; err_inc = 1'b1;
          end
        end else if (timeout) begin
          next = IDLE; err_inc = 1'b1;
        end
      end
      WAIT_LO: begin
        if (recv_error) begin
          next = IDLE; err_inc = 1'b1;
        end else if (received) begin
          lo_load = 1'b1; next = COMMIT;
        end else if (timeout) begin
          next = IDLE; err_inc = 1'b1;
        end
      end
      COMMIT: begin
        frame_ok = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      err_count  <= 8'd0;
      pending    <= X_RESET;
      pos_x_mano <= X_RESET;
    end else begin
      state <= next;
      if (in_wait && next == state && !received) tmo_cnt <= tmo_cnt + 1'b1;
      else                                       tmo_cnt <= '0;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (avg_vld)    pending    <= avg;
      if (frame_tick) pos_x_mano <= pending;
    end
  end

  // Frame payload registers carry no reset; they are only read after being loaded
  always_ff @(posedge clk) begin
    if (hi_load) hi  <= rx_byte[1:0];
    if (lo_load) raw <= {hi, rx_byte};
  end

  prom_movil #(
    .DATA_W   (10),
    .AVG_LOG2 (AVG_LOG2),
    .RESET_VAL(X_RESET)
  ) u_prom_movil (
    .clk       (clk),
    .reset     (reset),
    .sample_vld(state == COMMIT),
    .sample    (clamp_x(raw)),
    .avg       (avg),
    .avg_vld   (avg_vld)
  );

endmodule

// File: tb/tb_posicion_mano_rx.sv
// Directed bench for posicion_mano_rx with hand-computed expected positions.
module tb_posicion_mano_rx;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_byte;
  logic       received, recv_error, frame_tick;
  logic [9:0] pos_x_mano;
  logic       frame_ok;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int ok_base;

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_ok === 1'b1) ok_cnt <= ok_cnt + 1;

  posicion_mano_rx #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .received  (received),
    .recv_error(recv_error),
    .frame_tick(frame_tick),
    .pos_x_mano(pos_x_mano),
    .frame_ok  (frame_ok),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_byte = b; received = 1'b1;
    @(negedge clk); received = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic frame(input logic [7:0] h, input logic [7:0] l);
    send(8'hA5); send(h); send(l);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rx_byte = 8'h00; received = 1'b0; recv_error = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos", pos_x_mano, 288);
    check("rst_ok", frame_ok, 0);
    check("rst_err", err_count, 0);
    reset = 1'b0;

    // raw 400: (288*3+400)/4 = 316
    ok_base = ok_cnt;
    send(8'hA5); send(8'h01); send(8'h90);
    check("f1_ok_pulse", frame_ok, 1);
    @(negedge clk);
    check("f1_ok_drop", frame_ok, 0);
    repeat (3) @(negedge clk);
    check("f1_hold_no_tick", pos_x_mano, 288);
    tick();
    check("f1_pos", pos_x_mano, 316);
    check("f1_ok_count", ok_cnt - ok_base, 1);

    // raw 1023 clamps to 576; four frames flush the history
    ok_base = ok_cnt;
    for (int i = 0; i < 4; i++) frame(8'h03, 8'hFF);
    tick();
    check("clamp_pos", pos_x_mano, 576);
    check("clamp_ok_count", ok_cnt - ok_base, 4);

    // leading 00 ignored, A5 resync; history 576,576,576,100 -> 457
    send(8'h00); send(8'hA5); send(8'hA5); send(8'h00); send(8'h64);
    repeat (4) @(negedge clk);
    tick();
    check("resync_pos", pos_x_mano, 457);
    check("resync_err", err_count, 0);

    // bad high byte, then raw 200; history 576,576,100,200 -> 363
    ok_base = ok_cnt;
    send(8'hA5); send(8'h07);
    repeat (4) @(negedge clk);
    check("badhi_err", err_count, 1);
    check("badhi_no_ok", ok_cnt - ok_base, 0);
    frame(8'h00, 8'hC8);
    tick();
    check("after_bad_pos", pos_x_mano, 363);

    // inter-byte timeout
    send(8'hA5); send(8'h00);
    repeat (TO - 3) @(negedge clk);
    check("tmo_before", err_count, 1);
    repeat (10) @(negedge clk);
    check("tmo_after", err_count, 2);
    ok_base = ok_cnt;
    send(8'h10);
    repeat (4) @(negedge clk);
    check("tmo_lone_byte", ok_cnt - ok_base, 0);

    // recv_error wins over a simultaneous byte
    send(8'hA5);
    @(negedge clk); rx_byte = 8'h01; received = 1'b1; recv_error = 1'b1;
    @(negedge clk); received = 1'b0; recv_error = 1'b0;
    check("rxerr_err", err_count, 3);
    ok_base = ok_cnt;
    send(8'h2C);
    repeat (4) @(negedge clk);
    check("rxerr_byte_dropped", ok_cnt - ok_base, 0);
    @(negedge clk); recv_error = 1'b1;
    @(negedge clk); recv_error = 1'b0;
    check("rxerr_idle_ignored", err_count, 3);

    // tick coincides with pending update; raw 300 -> history 576,100,200,300 -> 294
    send(8'hA5); send(8'h01); send(8'h2C);
    tick();
    check("coincide_old", pos_x_mano, 363);
    tick();
    check("coincide_new", pos_x_mano, 294);

    // reset mid-frame acts immediately
    send(8'hA5); send(8'h01);
    @(negedge clk); reset = 1'b1;
    #1;
    check("midrst_pos", pos_x_mano, 288);
    check("midrst_err", err_count, 0);
    @(negedge clk); reset = 1'b0;
    send(8'h90);
    repeat (4) @(negedge clk);
    tick();
    check("midrst_partial_dropped", pos_x_mano, 288);
    frame(8'h01, 8'h90);
    tick();
    check("midrst_hist_reset", pos_x_mano, 316);

    // err_count saturates
    for (int i = 0; i < 260; i++) begin
      send(8'hA5); send(8'h07);
    end
    repeat (2) @(negedge clk);
    check("err_saturate", err_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
